// File: rtl/ysyx_25030093_mdu_pkg.sv
// Shared definitions for the RV32M multiply/divide unit: op encodings, FSM states and helpers.
package ysyx_25030093_mdu_pkg;

    localparam logic [2:0] MDU_MUL    = 3'd0;
    localparam logic [2:0] MDU_MULH   = 3'd1;
    localparam logic [2:0] MDU_MULHSU = 3'd2;
    localparam logic [2:0] MDU_MULHU  = 3'd3;
    localparam logic [2:0] MDU_DIV    = 3'd4;
    localparam logic [2:0] MDU_DIVU   = 3'd5;
    localparam logic [2:0] MDU_REM    = 3'd6;
    localparam logic [2:0] MDU_REMU   = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mdu_state_e;

    function automatic logic is_div(input logic [2:0] op);
        return op[2];
    endfunction

endpackage

// File: rtl/ysyx_25030093_mdu_step.sv
// One iteration of the MDU datapath: shift-add for multiply, restoring trial-subtract for divide.
module ysyx_25030093_mdu_step
    import ysyx_25030093_mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             div_mode,
    input  logic [WIDTH-1:0] hi,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] operand,
    output logic [WIDTH-1:0] hi_next,
    output logic [WIDTH-1:0] lo_next
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   acc;
    logic [WIDTH:0]   shifted;
    logic             fits;
    logic [WIDTH-1:0] trial;

    always_comb begin
        sum     = {1'b0, hi} + {1'b0, operand};
        acc     = lo[0] ? sum : {1'b0, hi};
        shifted = {hi, lo[WIDTH-1]};
        fits    = (shifted >= {1'b0, operand});
        // The partial remainder stays below the divisor, so the low WIDTH bits of the difference suffice.
        trial   = shifted[WIDTH-1:0] - operand;
        if (div_mode) begin
            hi_next = fits ? trial : shifted[WIDTH-1:0];
            lo_next = {lo[WIDTH-2:0], fits};
        end else begin
            hi_next = acc[WIDTH:1];
            lo_next = {acc[0], lo[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/ysyx_25030093_mdu.sv
// RV32M multi-cycle multiply/divide unit with valid/ready handshake and pass-through tag.
// Optional macro YSYX_25030093_MDU_FAST_MUL_EN selects a single-cycle combinational multiplier.
module ysyx_25030093_mdu
    import ysyx_25030093_mdu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] src1,
    input  logic [WIDTH-1:0] src2,
    input  logic [TAG_W-1:0] tag_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [TAG_W-1:0] tag_out,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH);

    mdu_state_e       state_reg, state_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic [2:0]       op_reg, op_next;
    logic [TAG_W-1:0] tag_reg, tag_next;
    logic [WIDTH-1:0] hi_reg, hi_next;
    logic [WIDTH-1:0] lo_reg, lo_next;
    logic [WIDTH-1:0] operand_reg, operand_next;
    logic             qneg_reg, qneg_next;
    logic             rneg_reg, rneg_next;
    logic             special_reg, special_next;
    logic [WIDTH-1:0] spec_res_reg, spec_res_next;
    logic [WIDTH-1:0] result_reg, result_next;
    logic [TAG_W-1:0] tag_out_reg, tag_out_next;
    logic             out_valid_reg, out_valid_next;
    logic             busy_reg, busy_next;

    logic [WIDTH-1:0] step_hi, step_lo;

    logic             s1_signed, s2_signed, a_neg, b_neg;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic             div_zero, div_ovf;
    logic [WIDTH-1:0] spec_val;
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0] quot_fix, rem_fix, final_val;

    ysyx_25030093_mdu_step #(.WIDTH(WIDTH)) u_step (
        .div_mode (is_div(op_reg)),
        .hi       (hi_reg),
        .lo       (lo_reg),
        .operand  (operand_reg),
        .hi_next  (step_hi),
        .lo_next  (step_lo)
    );

    // Operand decode at accept: signedness, magnitudes and the one-cycle divide corner cases.
    always_comb begin
        s1_signed = (op == MDU_MUL) || (op == MDU_MULH) || (op == MDU_MULHSU)
                 || (op == MDU_DIV) || (op == MDU_REM);
        s2_signed = (op == MDU_MUL) || (op == MDU_MULH) || (op == MDU_DIV) || (op == MDU_REM);
        a_neg     = s1_signed & src1[WIDTH-1];
        b_neg     = s2_signed & src2[WIDTH-1];
        mag_a     = a_neg ? -src1 : src1;
        mag_b     = b_neg ? -src2 : src2;
        div_zero  = is_div(op) && (src2 == '0);
        div_ovf   = ((op == MDU_DIV) || (op == MDU_REM))
                 && (src1 == {1'b1, {(WIDTH-1){1'b0}}}) && (src2 == '1);
        if (div_zero)
            spec_val = ((op == MDU_DIV) || (op == MDU_DIVU)) ? '1 : src1;
        else
            spec_val = (op == MDU_DIV) ? src1 : '0;
    end

    always_comb begin
        prod      = {hi_reg, lo_reg};
        prod_fix  = qneg_reg ? -prod : prod;
        quot_fix  = qneg_reg ? -lo_reg : lo_reg;
        rem_fix   = rneg_reg ? -hi_reg : hi_reg;
        if (is_div(op_reg))
            final_val = ((op_reg == MDU_DIV) || (op_reg == MDU_DIVU)) ? quot_fix : rem_fix;
        else
            final_val = (op_reg == MDU_MUL) ? prod_fix[WIDTH-1:0] : prod_fix[2*WIDTH-1:WIDTH];
    end

    always_comb begin
        state_next    = state_reg;
        count_next    = count_reg;
        op_next       = op_reg;
        tag_next      = tag_reg;
        hi_next       = hi_reg;
        lo_next       = lo_reg;
        operand_next  = operand_reg;
        qneg_next     = qneg_reg;
        rneg_next     = rneg_reg;
        special_next  = special_reg;
        spec_res_next = spec_res_reg;
        result_next   = result_reg;
        tag_out_next  = tag_out_reg;

        case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    op_next       = op;
                    tag_next      = tag_in;
                    operand_next  = mag_b;
                    hi_next       = '0;
                    lo_next       = mag_a;
                    qneg_next     = a_neg ^ b_neg;
                    rneg_next     = a_neg;
                    special_next  = div_zero | div_ovf;
                    spec_res_next = spec_val;
                    // Corner cases skip the iterations and land on the finishing step next cycle.
                    count_next    = (div_zero | div_ovf) ? CNT_LAST : '0;
`ifdef YSYX_25030093_MDU_FAST_MUL_EN
                    if (!is_div(op)) begin
                        {hi_next, lo_next} = (2*WIDTH)'(mag_a) * (2*WIDTH)'(mag_b);
                        count_next         = CNT_LAST;
                    end
`endif
                    state_next    = BUSY;
                end
            end
            BUSY: begin
                if (count_reg != CNT_LAST) begin
                    hi_next    = step_hi;
                    lo_next    = step_lo;
                    count_next = count_reg + 1'b1;
                end else begin
                    result_next  = special_reg ? spec_res_reg : final_val;
                    tag_out_next = tag_reg;
                    state_next   = DONE;
                end
            end
            DONE: begin
                if (out_ready)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase

        if (flush) begin
            state_next   = IDLE;
            count_next   = '0;
            result_next  = result_reg;
            tag_out_next = tag_out_reg;
        end

        out_valid_next = (state_next == DONE);
        busy_next      = (state_next != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            count_reg     <= '0;
            op_reg        <= '0;
            tag_reg       <= '0;
            hi_reg        <= '0;
            lo_reg        <= '0;
            operand_reg   <= '0;
            qneg_reg      <= 1'b0;
            rneg_reg      <= 1'b0;
            special_reg   <= 1'b0;
            spec_res_reg  <= '0;
            result_reg    <= '0;
            tag_out_reg   <= '0;
            out_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            count_reg     <= count_next;
            op_reg        <= op_next;
            tag_reg       <= tag_next;
            hi_reg        <= hi_next;
            lo_reg        <= lo_next;
            operand_reg   <= operand_next;
            qneg_reg      <= qneg_next;
            rneg_reg      <= rneg_next;
            special_reg   <= special_next;
            spec_res_reg  <= spec_res_next;
            result_reg    <= result_next;
            tag_out_reg   <= tag_out_next;
            out_valid_reg <= out_valid_next;
            busy_reg      <= busy_next;
        end
    end

    assign in_ready  = (state_reg == IDLE);
    assign out_valid = out_valid_reg;
    assign result    = result_reg;
    assign tag_out   = tag_out_reg;
    assign busy      = busy_reg;

endmodule

// File: tb/tb_ysyx_25030093_mdu.sv
// Directed self-checking bench for the multiply/divide unit with hand-computed expectations.
module tb_ysyx_25030093_mdu;

`ifdef YSYX_25030093_MDU_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif
    localparam int DIV_LAT = 33;
    localparam int SPC_LAT = 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  op = 3'd0;
    logic [31:0] src1 = '0;
    logic [31:0] src2 = '0;
    logic [4:0]  tag_in = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] result;
    logic [4:0]  tag_out;
    logic        busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ysyx_25030093_mdu #(.WIDTH(32), .TAG_W(5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .src1      (src1),
        .src2      (src2),
        .tag_in    (tag_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .tag_out   (tag_out),
        .busy      (busy)
    );

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    // Issue one request, wait (bounded) for out_valid, check latency/result/tag, then consume.
    task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] t,
                          input logic [31:0] exp_r, input int exp_lat);
        int cyc;
        op = o; src1 = a; src2 = b; tag_in = t; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        cyc = 0;
        while (!out_valid && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk({name, "_lat"}, 32'(cyc), 32'(exp_lat));
        chk({name, "_res"}, result, exp_r);
        chk({name, "_tag"}, 32'(tag_out), 32'(t));
        $display("op=%0d src1=%h src2=%h tag=%0d -> result=%h tag_out=%0d latency=%0d (%s)",
                 o, a, b, t, result, tag_out, cyc, name);
        @(posedge clk); #1;
    endtask

    initial begin
        int seen;
        logic [31:0] held_res;
        logic [4:0]  held_tag;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_tag", 32'(tag_out), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Multiply
        run_op("mul",    3'd0, 32'd7,        32'hFFFFFFFD, 5'd9,  32'hFFFFFFEB, MUL_LAT);
        run_op("mulh",   3'd1, 32'h80000000, 32'h80000000, 5'd1,  32'h40000000, MUL_LAT);
        run_op("mulhu",  3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2,  32'hFFFFFFFE, MUL_LAT);
        run_op("mulhsu", 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3,  32'hFFFFFFFF, MUL_LAT);

        // Divide
        run_op("div",    3'd4, 32'hFFFFFFF9, 32'd2, 5'd4,  32'hFFFFFFFD, DIV_LAT);
        run_op("rem",    3'd6, 32'hFFFFFFF9, 32'd2, 5'd5,  32'hFFFFFFFF, DIV_LAT);
        run_op("divu",   3'd5, 32'd100,      32'd7, 5'd6,  32'd14,       DIV_LAT);
        run_op("remu",   3'd7, 32'd100,      32'd7, 5'd7,  32'd2,        DIV_LAT);

        // Corner cases
        run_op("div0",   3'd4, 32'd5,        32'd0,        5'd10, 32'hFFFFFFFF, SPC_LAT);
        run_op("rem0",   3'd6, 32'd5,        32'd0,        5'd11, 32'd5,        SPC_LAT);
        run_op("divovf", 3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd12, 32'h80000000, SPC_LAT);
        run_op("removf", 3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd13, 32'd0,        SPC_LAT);

        // Back-pressure: hold result in DONE for 5 cycles
        op = 3'd5; src1 = 32'd100; src2 = 32'd7; tag_in = 5'd20; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        seen = 0;
        while (!out_valid && seen < 100) begin
            @(posedge clk); #1;
            seen++;
        end
        chk("hold_lat", 32'(seen), 32'd33);
        held_res = result;
        held_tag = tag_out;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_res", result, 32'd14);
            chk("hold_tag", 32'(tag_out), 32'(held_tag));
            chk("hold_in_ready", 32'(in_ready), 32'd0);
        end
        $display("hold: result=%h tag_out=%0d held=%h", result, tag_out, held_res);
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("release_in_ready", 32'(in_ready), 32'd1);
        chk("release_valid", 32'(out_valid), 32'd0);

        // Flush beats a same-cycle accept
        op = 3'd5; src1 = 32'd50; src2 = 32'd5; in_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
        chk("flush_acc_busy", 32'(busy), 32'd0);
        chk("flush_acc_in_ready", 32'(in_ready), 32'd1);

        // Flush mid-BUSY
        op = 3'd5; src1 = 32'd1000; src2 = 32'd3; tag_in = 5'd21; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("pre_flush_busy", 32'(busy), 32'd1);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_busy", 32'(busy), 32'd0);
        chk("flush_in_ready", 32'(in_ready), 32'd1);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        chk("flush_no_valid", 32'(seen), 32'd0);
        $display("flush: killed op produced %0d valid cycles", seen);
        run_op("divu_after_flush", 3'd5, 32'd9, 32'd3, 5'd22, 32'd3, DIV_LAT);

        // Reset mid-BUSY
        op = 3'd5; src1 = 32'd1000; src2 = 32'd3; tag_in = 5'd23; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("mrst_out_valid", 32'(out_valid), 32'd0);
        chk("mrst_result", result, 32'd0);
        chk("mrst_tag", 32'(tag_out), 32'd0);
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_op("divu_after_rst", 3'd5, 32'd9, 32'd3, 5'd24, 32'd3, DIV_LAT);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
